alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter SNOOZE_SECS, default 300, snooze duration in clk_1Hz cycles (1..511).
REQ-002 SHALL have parameter RING_SECS, default 60, maximum ringing duration in cycles (1..255).
REQ-003 SHALL have parameter MAX_SNOOZES, default 3, snoozes allowed per alarm event (0..7).
REQ-004 SHALL have port clk_1Hz, input, 1, clock; reset reset, asynchronous, active-high; clock clk_1Hz.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port sec, input, 6, current seconds 0..59 from the time counter.
REQ-007 SHALL have port min, input, 6, current minutes 0..59.
REQ-008 SHALL have port hrs, input, 5, current hours 0..23.
REQ-009 SHALL have port set_hrs, input, 5, alarm hour to load.
REQ-010 SHALL have port set_min, input, 6, alarm minute to load.
REQ-011 SHALL have port set_load, input, 1, level-sampled load strobe for set_hrs/set_min.
REQ-012 SHALL have ports arm, disarm, stop, snooze, each input, 1, sampled once per cycle.
REQ-013 SHALL have port buzzer, output, 1, high while in RINGING.
REQ-014 SHALL have port alarm_state, output, 2, encoded state: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-015 SHALL have port alarm_hit, output, 1, one-cycle pulse on each ARMED->RINGING entry.
REQ-016 SHALL have port snooze_left, output, 9, remaining SNOOZE cycles, 0 outside SNOOZE.

Function
REQ-017 SHALL hold alarm time in registers alm_hrs/alm_min, loaded on any cycle with set_load=1 in any state.
REQ-018 SHALL ignore set_load when set_hrs>23 or set_min>59; stored alarm time is then unchanged.
REQ-019 SHALL define match = (hrs==alm_hrs && min==alm_min && sec==0), evaluated on the sampled inputs.
REQ-020 SHALL transition IDLE->ARMED on arm=1; arm in other states has no effect.
REQ-021 SHALL transition ARMED->RINGING on the edge where match=1; buzzer and alarm_hit high in the following cycle (1-cycle latency).
REQ-022 SHALL, in RINGING, count cycles; after RING_SECS cycles with no stop/snooze, return to ARMED (auto-silence, alarm stays armed for next day).
REQ-023 SHALL transition RINGING->ARMED on stop=1, reset snooze count to 0.
REQ-024 SHALL transition RINGING->SNOOZE on snooze=1 when snoozes_used<MAX_SNOOZES, load snooze_left=SNOOZE_SECS, increment snoozes_used; otherwise ignore snooze.
REQ-025 SHALL decrement snooze_left each SNOOZE cycle; on the cycle snooze_left==1 transition to RINGING with ring counter cleared (SNOOZE lasts exactly SNOOZE_SECS cycles); alarm_hit not pulsed.
REQ-026 SHALL transition SNOOZE->ARMED on stop=1, clearing snooze_left and snoozes_used.
REQ-027 SHALL transition any state->IDLE on disarm=1; priority disarm > stop > snooze > arm > match > timeouts.
REQ-028 SHALL ignore match while in RINGING or SNOOZE (no re-trigger, no alarm_hit).
REQ-029 SHALL clear snoozes_used on every ARMED->RINGING entry.

Reset
REQ-030 SHALL, on reset, set state IDLE, buzzer=0, alarm_hit=0, snooze_left=0, snoozes_used=0, ring counter=0, alm_hrs=0, alm_min=0.
REQ-031 SHALL abort ringing or snoozing immediately on reset assertion mid-operation, without waiting for a clock edge.

Configuration
REQ-032 SHALL provide macro ALARM_SNOOZE_EN; when defined, REQ-024..REQ-026 apply.
REQ-033 SHALL, when ALARM_SNOOZE_EN is undefined, ignore snooze, make SNOOZE unreachable, tie snooze_left to 0, omit snooze counters.

Structure
REQ-034 SHALL place state encoding, widths (SEC_W=6, MIN_W=6, HRS_W=5) and limits (23, 59) in shared package alarm_pkg.
REQ-035 SHALL implement the snooze/ring cycle counting in one sub-module alarm_countdown (load, enable, zero flag).

Verification
REQ-036 SHALL cover: set 07:30, arm, drive time 07:29:59->07:30:00 -> buzzer=1, alarm_hit one pulse, state=2 next cycle.
REQ-037 SHALL cover: ringing, no input for 60 cycles -> state returns to 1, buzzer=0 on cycle 61.
REQ-038 SHALL cover: SNOOZE_SECS=5, snooze while ringing -> state=3, snooze_left 5,4,3,2,1, then state=2, alarm_hit stays 0.
REQ-039 SHALL cover: MAX_SNOOZES=3, four snooze pulses across ringing periods -> fourth ignored, state stays 2.
REQ-040 SHALL cover: set_load with set_hrs=24 or set_min=60 -> alarm time unchanged; disarm and stop same cycle -> state=0.
REQ-041 SHALL cover: reset asserted mid-SNOOZE -> state=0, buzzer=0, snooze_left=0 immediately.

Source files
------------

// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alarm_pkg
// Brief   : Shared widths, time limits, state encoding and helpers for the
//           alarm controller and its countdown sub-block.
// Revision: 1.0 - initial release
// ============================================================================
package alarm_pkg;

  // Time-of-day field widths as delivered by the time counter
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HRS_W  = 5;

  // Largest legal hour / minute values
  localparam int HRS_MAX = 23;
  localparam int MIN_MAX = 59;

  // Counter widths: snooze duration (1..511), ring duration (1..255),
  // snoozes used per alarm event (0..7)
  localparam int SNZ_W  = 9;
  localparam int RING_W = 8;
  localparam int USED_W = 3;

  // Externally visible state encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_e;

  // True when an hour/minute pair is a legal time of day
  function automatic logic time_valid(input logic [HRS_W-1:0] h,
                                      input logic [MIN_W-1:0] m);
    return (h <= HRS_W'(HRS_MAX)) && (m <= MIN_W'(MIN_MAX));
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_countdown.sv
`default_nettype none
// ============================================================================
// Module  : alarm_countdown
// Brief   : Loadable down-counter with clear, enable and zero flag. Used for
//           both the ringing timeout and the snooze interval.
// Revision: 1.0 - initial release
// ============================================================================
module alarm_countdown #(
  parameter int WIDTH = 8
) (
  input  logic             clk_1Hz,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear beats load, load beats decrement; holds at zero
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alarm_ctrl
// Brief   : Alarm clock controller. Stores an alarm time, rings the buzzer
//           when the time of day matches, auto-silences after RING_SECS and
//           optionally supports a limited number of snoozes.
// Config  : define ALARM_SNOOZE_EN to build the snooze feature; without it
//           the snooze input is ignored and snooze_left is tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SECS = 300,
  parameter int RING_SECS   = 60,
  parameter int MAX_SNOOZES = 3
) (
  input  logic             clk_1Hz,
  input  logic             reset,
  input  logic [SEC_W-1:0] sec,
  input  logic [MIN_W-1:0] min,
  input  logic [HRS_W-1:0] hrs,
  input  logic [HRS_W-1:0] set_hrs,
  input  logic [MIN_W-1:0] set_min,
  input  logic             set_load,
  input  logic             arm,
  input  logic             disarm,
  input  logic             stop,
  input  logic             snooze,
  output logic             buzzer,
  output logic [1:0]       alarm_state,
  output logic             alarm_hit,
  output logic [SNZ_W-1:0] snooze_left
);

  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECS);

  alarm_state_e     state_q;
  alarm_state_e     state_d;
  logic             alarm_hit_q;
  logic             alarm_hit_d;
  logic [HRS_W-1:0] alm_hrs_q;
  logic [MIN_W-1:0] alm_min_q;
  logic             match;

  logic              ring_load;
  logic              ring_clr;
  logic              ring_en;
  logic [RING_W-1:0] ring_count;
  logic              ring_zero;
  logic              ring_done;

`ifdef ALARM_SNOOZE_EN
  localparam logic [SNZ_W-1:0]  SNZ_LOAD = SNZ_W'(SNOOZE_SECS);
  localparam logic [USED_W-1:0] USED_MAX = USED_W'(MAX_SNOOZES);

  logic              snz_load;
  logic              snz_clr;
  logic              snz_en;
  logic [SNZ_W-1:0]  snz_count;
  logic              snz_zero;
  logic              snz_done;
  logic              snooze_ok;
  logic [USED_W-1:0] snoozes_used_q;
  logic [USED_W-1:0] snoozes_used_d;
`endif

  // Alarm fires only at the top of the matching minute
  assign match = (hrs == alm_hrs_q) && (min == alm_min_q) && (sec == '0);

  // The count==0 term covers a count that somehow never reached one
  assign ring_done = (ring_count == RING_W'(1)) || ring_zero;

  alarm_countdown #(
    .WIDTH (RING_W)
  ) u_ring_cnt (
    .clk_1Hz    (clk_1Hz),
    .reset      (reset),
    .clr_i      (ring_clr),
    .load_i     (ring_load),
    .load_val_i (RING_LOAD),
    .en_i       (ring_en),
    .count_o    (ring_count),
    .zero_o     (ring_zero)
  );

`ifdef ALARM_SNOOZE_EN
  assign snooze_ok = snooze && (snoozes_used_q < USED_MAX);
  assign snz_done  = (snz_count == SNZ_W'(1)) || snz_zero;

  alarm_countdown #(
    .WIDTH (SNZ_W)
  ) u_snz_cnt (
    .clk_1Hz    (clk_1Hz),
    .reset      (reset),
    .clr_i      (snz_clr),
    .load_i     (snz_load),
    .load_val_i (SNZ_LOAD),
    .en_i       (snz_en),
    .count_o    (snz_count),
    .zero_o     (snz_zero)
  );

  assign snooze_left = (state_q == ST_SNOOZE) ? snz_count : '0;

  // Snoozes consumed during the current alarm event
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      snoozes_used_q <= '0;
    end else begin
      snoozes_used_q <= snoozes_used_d;
    end
  end
`else
  // Snooze feature absent: input and snooze parameters have no effect
  logic unused_snooze;
  assign unused_snooze = ^{snooze, SNZ_W'(SNOOZE_SECS), USED_W'(MAX_SNOOZES)};
  assign snooze_left   = '0;
`endif

  // Alarm time registers; out-of-range load requests are dropped
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      alm_hrs_q <= '0;
      alm_min_q <= '0;
    end else if (set_load && time_valid(set_hrs, set_min)) begin
      alm_hrs_q <= set_hrs;
      alm_min_q <= set_min;
    end
  end

  // State and hit-pulse registers
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      alarm_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alarm_hit_q <= alarm_hit_d;
    end
  end

  // Next state and counter controls; priority disarm > stop > snooze > arm >
  // match > timeouts
  always_comb begin
    state_d     = state_q;
    alarm_hit_d = 1'b0;
    ring_load   = 1'b0;
    ring_clr    = 1'b0;
    ring_en     = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_load       = 1'b0;
    snz_clr        = 1'b0;
    snz_en         = 1'b0;
    snoozes_used_d = snoozes_used_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!disarm && arm) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          state_d = ST_IDLE;
        end else if (match) begin
          state_d     = ST_RINGING;
          alarm_hit_d = 1'b1;
          ring_load   = 1'b1;
`ifdef ALARM_SNOOZE_EN
          snoozes_used_d = '0;
`endif
        end
      end
      ST_RINGING: begin
        if (disarm) begin
          state_d  = ST_IDLE;
          ring_clr = 1'b1;
`ifdef ALARM_SNOOZE_EN
          snoozes_used_d = '0;
`endif
        end else if (stop) begin
          state_d  = ST_ARMED;
          ring_clr = 1'b1;
`ifdef ALARM_SNOOZE_EN
          snoozes_used_d = '0;
        end else if (snooze_ok) begin
          state_d        = ST_SNOOZE;
          ring_clr       = 1'b1;
          snz_load       = 1'b1;
          snoozes_used_d = snoozes_used_q + USED_W'(1);
`endif
        end else if (ring_done) begin
          // Auto-silence: stay armed for the next day
          state_d  = ST_ARMED;
          ring_clr = 1'b1;
        end else begin
          ring_en = 1'b1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (disarm) begin
          state_d        = ST_IDLE;
          snz_clr        = 1'b1;
          snoozes_used_d = '0;
        end else if (stop) begin
          state_d        = ST_ARMED;
          snz_clr        = 1'b1;
          snoozes_used_d = '0;
        end else if (snz_done) begin
          // Resume ringing with a fresh ring period, no hit pulse
          state_d   = ST_RINGING;
          snz_clr   = 1'b1;
          ring_load = 1'b1;
        end else begin
          snz_en = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign buzzer      = (state_q == ST_RINGING);
  assign alarm_state = state_q;
  assign alarm_hit   = alarm_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alarm_ctrl
// Brief   : Directed self-checking bench for alarm_ctrl with a scoreboard of
//           expected outputs. Snooze scenarios follow ALARM_SNOOZE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alarm_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RING = 2'd2;
  localparam logic [1:0] S_SNZ  = 2'd3;

  logic       clk_1Hz = 1'b0;
  logic       reset;
  logic [5:0] t_sec;
  logic [5:0] t_min;
  logic [4:0] t_hrs;
  logic [4:0] set_hrs;
  logic [5:0] set_min;
  logic       set_load;
  logic       arm;
  logic       disarm;
  logic       stop;
  logic       snooze;
  logic       buzzer;
  logic [1:0] alarm_state;
  logic       alarm_hit;
  logic [8:0] snooze_left;

  always #5 clk_1Hz = ~clk_1Hz;

  alarm_ctrl #(
    .SNOOZE_SECS (5),
    .RING_SECS   (60),
    .MAX_SNOOZES (3)
  ) dut (
    .clk_1Hz     (clk_1Hz),
    .reset       (reset),
    .sec         (t_sec),
    .min         (t_min),
    .hrs         (t_hrs),
    .set_hrs     (set_hrs),
    .set_min     (set_min),
    .set_load    (set_load),
    .arm         (arm),
    .disarm      (disarm),
    .stop        (stop),
    .snooze      (snooze),
    .buzzer      (buzzer),
    .alarm_state (alarm_state),
    .alarm_hit   (alarm_hit),
    .snooze_left (snooze_left)
  );

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       bz;
    logic       hit;
    logic [8:0] left;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push_exp(input string tag, input logic [1:0] st, input logic bz,
                          input logic hit, input logic [8:0] left);
    exp_t e;
    e.tag  = tag;
    e.st   = st;
    e.bz   = bz;
    e.hit  = hit;
    e.left = left;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got 0 entries required 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (alarm_state === e.st) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", e.tag, alarm_state, e.st);
    end
    checks++;
    assert (buzzer === e.bz) else begin
      errors++;
      $error("FAIL %s buzzer: got %0b expected %0b", e.tag, buzzer, e.bz);
    end
    checks++;
    assert (alarm_hit === e.hit) else begin
      errors++;
      $error("FAIL %s alarm_hit: got %0b expected %0b", e.tag, alarm_hit, e.hit);
    end
    checks++;
    assert (snooze_left === e.left) else begin
      errors++;
      $error("FAIL %s snooze_left: got %0d expected %0d", e.tag, snooze_left, e.left);
    end
  endtask

  // Expect these outputs after the next rising edge
  task automatic cyc(input string tag, input logic [1:0] st, input logic bz,
                     input logic hit, input logic [8:0] left);
    push_exp(tag, st, bz, hit, left);
    @(posedge clk_1Hz);
    #1;
    check_out();
  endtask

  // Expect these outputs right now, with no clock edge
  task automatic now_chk(input string tag, input logic [1:0] st, input logic bz,
                         input logic hit, input logic [8:0] left);
    push_exp(tag, st, bz, hit, left);
    check_out();
  endtask

  // From ARMED, walk the clock across 07:29:59 -> 07:30:00
  task automatic trigger(input string tag);
    t_hrs = 5'd7;
    t_min = 6'd29;
    t_sec = 6'd59;
    cyc({tag, "_pre"}, S_ARM, 1'b0, 1'b0, 9'd0);
    t_min = 6'd30;
    t_sec = 6'd0;
    cyc({tag, "_hit"}, S_RING, 1'b1, 1'b1, 9'd0);
    t_sec = 6'd1;
  endtask

`ifdef ALARM_SNOOZE_EN
  // One full snooze interval of 5 cycles, then back to ringing
  task automatic snooze_round(input string tag);
    snooze = 1'b1;
    cyc({tag, "_enter"}, S_SNZ, 1'b0, 1'b0, 9'd5);
    snooze = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      cyc({tag, "_count"}, S_SNZ, 1'b0, 1'b0, 9'(k));
    end
    cyc({tag, "_resume"}, S_RING, 1'b1, 1'b0, 9'd0);
  endtask
`endif

  initial begin
    reset    = 1'b1;
    t_hrs    = 5'd12;
    t_min    = 6'd0;
    t_sec    = 6'd1;
    set_hrs  = 5'd0;
    set_min  = 6'd0;
    set_load = 1'b0;
    arm      = 1'b0;
    disarm   = 1'b0;
    stop     = 1'b0;
    snooze   = 1'b0;

    #2;
    now_chk("reset", S_IDLE, 1'b0, 1'b0, 9'd0);
    @(negedge clk_1Hz);
    reset = 1'b0;

    // Load 07:30
    set_hrs  = 5'd7;
    set_min  = 6'd30;
    set_load = 1'b1;
    cyc("load_0730", S_IDLE, 1'b0, 1'b0, 9'd0);
    set_load = 1'b0;

    // Disarm outranks arm
    arm    = 1'b1;
    disarm = 1'b1;
    cyc("arm_vs_disarm", S_IDLE, 1'b0, 1'b0, 9'd0);
    disarm = 1'b0;
    cyc("arm", S_ARM, 1'b0, 1'b0, 9'd0);
    arm = 1'b0;

    // Out-of-range loads must leave 07:30 in place
    set_hrs  = 5'd24;
    set_min  = 6'd0;
    set_load = 1'b1;
    cyc("bad_hrs_load", S_ARM, 1'b0, 1'b0, 9'd0);
    set_hrs  = 5'd0;
    set_min  = 6'd60;
    cyc("bad_min_load", S_ARM, 1'b0, 1'b0, 9'd0);
    set_load = 1'b0;

    // Ring, then auto-silence after exactly 60 ringing cycles
    trigger("ring1");
    for (int i = 2; i <= 60; i++) begin
      cyc("ringing", S_RING, 1'b1, 1'b0, 9'd0);
    end
    cyc("auto_silence", S_ARM, 1'b0, 1'b0, 9'd0);

    // Snooze handling
    trigger("ring2");
`ifdef ALARM_SNOOZE_EN
    snooze_round("snz1");
    snooze_round("snz2");
    snooze_round("snz3");
    snooze = 1'b1;
    cyc("snooze_4th_ignored", S_RING, 1'b1, 1'b0, 9'd0);
    snooze = 1'b0;
`else
    snooze = 1'b1;
    cyc("snooze_ignored", S_RING, 1'b1, 1'b0, 9'd0);
    snooze = 1'b0;
    cyc("still_ringing", S_RING, 1'b1, 1'b0, 9'd0);
`endif

    // Stop while ringing
    stop = 1'b1;
    cyc("stop_ring", S_ARM, 1'b0, 1'b0, 9'd0);
    stop = 1'b0;

    // Disarm and stop together -> IDLE
    trigger("ring_ds");
    disarm = 1'b1;
    stop   = 1'b1;
    cyc("disarm_and_stop", S_IDLE, 1'b0, 1'b0, 9'd0);
    disarm = 1'b0;
    stop   = 1'b0;
    arm    = 1'b1;
    cyc("rearm", S_ARM, 1'b0, 1'b0, 9'd0);
    arm = 1'b0;

    // Asynchronous reset in the middle of snoozing (or ringing)
    trigger("ring3");
`ifdef ALARM_SNOOZE_EN
    snooze = 1'b1;
    cyc("snz_after_stop", S_SNZ, 1'b0, 1'b0, 9'd5);
    snooze = 1'b0;
    cyc("snz_mid", S_SNZ, 1'b0, 1'b0, 9'd4);
`else
    cyc("ring_mid", S_RING, 1'b1, 1'b0, 9'd0);
`endif
    #2;
    reset = 1'b1;
    #1;
    now_chk("async_reset", S_IDLE, 1'b0, 1'b0, 9'd0);
    @(negedge clk_1Hz);
    reset = 1'b0;
    cyc("post_reset", S_IDLE, 1'b0, 1'b0, 9'd0);

    // Reset also cleared the alarm time to 00:00
    arm = 1'b1;
    cyc("arm_after_reset", S_ARM, 1'b0, 1'b0, 9'd0);
    arm   = 1'b0;
    t_hrs = 5'd0;
    t_min = 6'd0;
    t_sec = 6'd0;
    cyc("ring_0000", S_RING, 1'b1, 1'b1, 9'd0);
    t_sec = 6'd1;
    stop  = 1'b1;
    cyc("stop_0000", S_ARM, 1'b0, 1'b0, 9'd0);
    stop = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
